// File: rtl/ob_cmd_deserializer.sv
// Byte-stream to order-book command assembler: 14-byte MSB-first frames, validation,
// drop counting and partial-frame idle timeout, with a registered valid/ready output.
`timescale 1ns/1ps
module ob_cmd_deserializer #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int ERR_CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_vld,
    input  logic [7:0]           in_dat,
    output logic                 in_rdy,
    output logic                 cmd_vld_r,
    output logic [106:0]         cmd_r,
    input  logic                 cmd_accept,
    output logic                 drop_r,
    output logic [ERR_CNT_W-1:0] err_cnt_r
);
    localparam int IDLE_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [3:0] LAST_BYTE = 4'd13;

    localparam logic [3:0] OP_NOP          = 4'd0;
    localparam logic [3:0] OP_QRY_BID_ASK  = 4'd1;
    localparam logic [3:0] OP_BUY_LIMIT    = 4'd2;
    localparam logic [3:0] OP_SELL_LIMIT   = 4'd3;
    localparam logic [3:0] OP_POP_TOP_BID  = 4'd4;
    localparam logic [3:0] OP_POP_TOP_ASK  = 4'd5;
    localparam logic [3:0] OP_CANCEL       = 4'd6;
    localparam logic [3:0] OP_BUY_MARKET   = 4'd8;
    localparam logic [3:0] OP_SELL_MARKET  = 4'd9;
    localparam logic [3:0] OP_QRY_TBL_ASK  = 4'd10;
    localparam logic [3:0] OP_QRY_TBL_BID  = 4'd11;
    localparam logic [2:0] TIF_ALL_OR_NONE = 3'd3;

    logic [3:0]           byte_cnt_q, byte_cnt_d;
    logic [IDLE_W-1:0]    idle_cnt_q, idle_cnt_d;
    logic [103:0]         shreg_q, shreg_d;
    logic                 cmd_vld_q, cmd_vld_d;
    logic [106:0]         cmd_q, cmd_d;
    logic                 drop_q, drop_d;
    logic [ERR_CNT_W-1:0] err_q, err_d;

    logic         timeout, rdy, accept, frame_done, op_ok, frame_ok;
    logic [111:0] word;

    assign timeout = (TIMEOUT_CYCLES != 0) && (idle_cnt_q == IDLE_W'(TIMEOUT_CYCLES));
    // The last byte waits for the held command to leave; the timeout cycle refuses bytes.
    assign rdy        = !((byte_cnt_q == LAST_BYTE) && cmd_vld_q) && !timeout;
    assign accept     = in_vld && rdy;
    assign frame_done = accept && (byte_cnt_q == LAST_BYTE);
    assign word       = {shreg_q, in_dat};

    always_comb begin
        op_ok = 1'b0;
        case (word[74:71])
            OP_NOP, OP_QRY_BID_ASK, OP_BUY_LIMIT, OP_SELL_LIMIT, OP_POP_TOP_BID,
            OP_POP_TOP_ASK, OP_CANCEL, OP_BUY_MARKET, OP_SELL_MARKET,
            OP_QRY_TBL_ASK, OP_QRY_TBL_BID: op_ok = 1'b1;
            default:                        op_ok = 1'b0;
        endcase
    end

    assign frame_ok = (word[111:107] == 5'd0) && op_ok && (word[70:68] <= TIF_ALL_OR_NONE)
                      && (word[106:75] != 32'hFFFF_FFFF);

    always_comb begin
        byte_cnt_d = byte_cnt_q;
        idle_cnt_d = idle_cnt_q;
        shreg_d    = shreg_q;
        if (timeout) begin
            byte_cnt_d = 4'd0;
            idle_cnt_d = '0;
        end else if (accept) begin
            shreg_d    = {shreg_q[95:0], in_dat};
            byte_cnt_d = frame_done ? 4'd0 : byte_cnt_q + 4'd1;
            idle_cnt_d = '0;
        end else if (!rdy) begin
            idle_cnt_d = '0;
        end else if ((byte_cnt_q != 4'd0) && (TIMEOUT_CYCLES != 0)) begin
            idle_cnt_d = idle_cnt_q + 1'b1;
        end
    end

    always_comb begin
        cmd_vld_d = cmd_vld_q;
        cmd_d     = cmd_q;
        if (frame_done && frame_ok) begin
            cmd_vld_d = 1'b1;
            cmd_d     = word[106:0];
        end else if (cmd_vld_q && cmd_accept) begin
            cmd_vld_d = 1'b0;
        end
    end

    // A timeout can never land on a completing byte since in_rdy is low then.
    assign drop_d = (frame_done && !frame_ok) || timeout;
    assign err_d  = (drop_d && (err_q != '1)) ? err_q + 1'b1 : err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt_q <= 4'd0;
            idle_cnt_q <= '0;
            shreg_q    <= '0;
            cmd_vld_q  <= 1'b0;
            cmd_q      <= '0;
            drop_q     <= 1'b0;
            err_q      <= '0;
        end else begin
            byte_cnt_q <= byte_cnt_d;
            idle_cnt_q <= idle_cnt_d;
            shreg_q    <= shreg_d;
            cmd_vld_q  <= cmd_vld_d;
            cmd_q      <= cmd_d;
            drop_q     <= drop_d;
            err_q      <= err_d;
        end
    end

    assign in_rdy    = rdy;
    assign cmd_vld_r = cmd_vld_q;
    assign cmd_r     = cmd_q;
    assign drop_r    = drop_q;
    assign err_cnt_r = err_q;
endmodule

// File: tb/tb_ob_cmd_deserializer.sv
// Directed bench for ob_cmd_deserializer: one instance with a short timeout, one with a
// 2-bit error counter sharing the same byte stream.
`timescale 1ns/1ps
module tb_ob_cmd_deserializer;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_vld = 1'b0;
    logic [7:0]   in_dat = 8'h00;
    logic         cmd_accept = 1'b0;
    logic         in_rdy, cmd_vld_r, drop_r;
    logic [106:0] cmd_r;
    logic [15:0]  err_cnt_r;
    logic         in_rdy_s, cmd_vld_s, drop_s;
    logic [106:0] cmd_s;
    logic [1:0]   err_s;

    int n_chk = 0, n_err = 0;
    int drop_cnt = 0, drop_s_cnt = 0, vld_cyc = 0;
    logic [106:0] xq[$];

    always #5 clk = ~clk;

    ob_cmd_deserializer #(.TIMEOUT_CYCLES(8), .ERR_CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_dat(in_dat), .in_rdy(in_rdy),
        .cmd_vld_r(cmd_vld_r), .cmd_r(cmd_r), .cmd_accept(cmd_accept),
        .drop_r(drop_r), .err_cnt_r(err_cnt_r));

    ob_cmd_deserializer #(.TIMEOUT_CYCLES(0), .ERR_CNT_W(2)) dut_s (
        .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_dat(in_dat), .in_rdy(in_rdy_s),
        .cmd_vld_r(cmd_vld_s), .cmd_r(cmd_s), .cmd_accept(cmd_accept),
        .drop_r(drop_s), .err_cnt_r(err_s));

    always @(negedge clk) begin
        if (drop_r) drop_cnt++;
        if (drop_s) drop_s_cnt++;
        if (cmd_vld_r) vld_cyc++;
        if (cmd_vld_r && cmd_accept) xq.push_back(cmd_r);
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [111:0] mk(input logic [31:0] uid, input logic [3:0] op,
                                        input logic [2:0] tif, input logic [19:0] price,
                                        input logic [15:0] qty, input logic [31:0] uid1);
        return {5'b0, uid, op, tif, price, qty, uid1};
    endfunction

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        in_vld = 1'b1;
        in_dat = b;
        forever begin
            @(negedge clk);
            if (in_rdy) break;
            n++;
            if (n > 200) begin
                chk("in_rdy_timeout", 128'(in_rdy), 128'(1));
                break;
            end
        end
        @(posedge clk);
        #1 in_vld = 1'b0;
    endtask

    task automatic send_bytes(input logic [111:0] w, input int first, input int last);
        for (int i = first; i <= last; i++) send_byte(w[111-8*i -: 8]);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_vld = 1'b0;
        cmd_accept = 1'b0;
        rst_n = 1'b0;
        cycles(3);
        rst_n = 1'b1;
        cycles(1);
    endtask

    logic [111:0] fa, fb, fc, fbad;

    initial begin
        fa = mk(32'h0000_0010, 4'd2, 3'd0, 20'h00100, 16'h0064, 32'h0);
        fb = mk(32'h0000_1234, 4'd3, 3'd1, 20'hABCDE, 16'h00FF, 32'hDEAD_BEEF);
        fc = mk(32'h00C0_FFEE, 4'd11, 3'd3, 20'h00042, 16'h0007, 32'h1111_2222);

        // reset state
        rst_n = 1'b0;
        #7;
        chk("rst_vld", 128'(cmd_vld_r), 128'(0));
        chk("rst_cmd", 128'(cmd_r), 128'(0));
        chk("rst_drop", 128'(drop_r), 128'(0));
        chk("rst_err", 128'(err_cnt_r), 128'(0));
        chk("rst_rdy", 128'(in_rdy), 128'(1));
        do_reset();

        // single valid frame, downstream always ready
        cmd_accept = 1'b1;
        vld_cyc = 0;
        send_bytes(fa, 0, 13);
        @(negedge clk);
        chk("t1_vld", 128'(cmd_vld_r), 128'(1));
        chk("t1_cmd", 128'(cmd_r), 128'(fa[106:0]));
        @(negedge clk);
        chk("t1_vld_clr", 128'(cmd_vld_r), 128'(0));
        cycles(2);
        chk("t1_vld_cyc", 128'(vld_cyc), 128'(1));
        chk("t1_err", 128'(err_cnt_r), 128'(0));

        // back-to-back frames, downstream stalled
        cmd_accept = 1'b0;
        xq.delete();
        send_bytes(fa, 0, 13);
        send_bytes(fb, 0, 12);
        in_vld = 1'b1;
        in_dat = fb[7:0];
        @(negedge clk);
        chk("t2_stall_rdy", 128'(in_rdy), 128'(0));
        chk("t2_hold_cmd", 128'(cmd_r), 128'(fa[106:0]));
        repeat (19) @(negedge clk);
        chk("t2_stall_rdy20", 128'(in_rdy), 128'(0));
        chk("t2_hold_vld", 128'(cmd_vld_r), 128'(1));
        @(posedge clk);
        #1 cmd_accept = 1'b1;
        send_byte(fb[7:0]);
        @(negedge clk);
        chk("t2_vld2", 128'(cmd_vld_r), 128'(1));
        chk("t2_cmd2", 128'(cmd_r), 128'(fb[106:0]));
        cycles(2);
        chk("t2_xfers", 128'(xq.size()), 128'(2));
        if (xq.size() == 2) begin
            chk("t2_x0", 128'(xq[0]), 128'(fa[106:0]));
            chk("t2_x1", 128'(xq[1]), 128'(fb[106:0]));
        end

        // invalid frames: opcode 7, reserved uid, nonzero padding
        vld_cyc = 0;
        drop_cnt = 0;
        send_bytes(mk(32'h5, 4'd7, 3'd0, 20'h1, 16'h1, 32'h0), 0, 13);
        send_bytes(mk(32'hFFFF_FFFF, 4'd2, 3'd0, 20'h1, 16'h1, 32'h0), 0, 13);
        fbad = fa;
        fbad[111:104] = 8'h08;
        send_bytes(fbad, 0, 13);
        cycles(3);
        chk("t3_drops", 128'(drop_cnt), 128'(3));
        chk("t3_err", 128'(err_cnt_r), 128'(3));
        chk("t3_no_vld", 128'(vld_cyc), 128'(0));

        // idle timeout with 8-cycle limit, then resync on a valid frame
        do_reset();
        cmd_accept = 1'b1;
        drop_cnt = 0;
        xq.delete();
        send_bytes(fb, 0, 4);
        repeat (8) @(negedge clk);
        chk("t4_rdy_pre", 128'(in_rdy), 128'(1));
        chk("t4_no_drop_pre", 128'(drop_r), 128'(0));
        @(negedge clk);
        chk("t4_rdy_to", 128'(in_rdy), 128'(0));
        @(negedge clk);
        chk("t4_drop", 128'(drop_r), 128'(1));
        chk("t4_err", 128'(err_cnt_r), 128'(1));
        @(posedge clk);
        #1;
        send_bytes(fc, 0, 13);
        @(negedge clk);
        chk("t4_vld", 128'(cmd_vld_r), 128'(1));
        chk("t4_cmd", 128'(cmd_r), 128'(fc[106:0]));
        cycles(2);
        chk("t4_drops", 128'(drop_cnt), 128'(1));

        // reset mid-frame while a command is held
        cmd_accept = 1'b0;
        send_bytes(fa, 0, 13);
        send_bytes(fb, 0, 7);
        @(negedge clk);
        chk("t5_pre_vld", 128'(cmd_vld_r), 128'(1));
        xq.delete();
        drop_cnt = 0;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_vld", 128'(cmd_vld_r), 128'(0));
        chk("t5_rst_cmd", 128'(cmd_r), 128'(0));
        chk("t5_rst_err", 128'(err_cnt_r), 128'(0));
        chk("t5_rst_drop", 128'(drop_r), 128'(0));
        cycles(2);
        rst_n = 1'b1;
        cycles(1);
        cmd_accept = 1'b1;
        send_bytes(fc, 0, 13);
        cycles(3);
        chk("t5_xfers", 128'(xq.size()), 128'(1));
        if (xq.size() == 1) chk("t5_x0", 128'(xq[0]), 128'(fc[106:0]));
        chk("t5_err", 128'(err_cnt_r), 128'(0));
        chk("t5_drops", 128'(drop_cnt), 128'(0));

        // saturation of a 2-bit counter
        drop_s_cnt = 0;
        for (int k = 0; k < 5; k++)
            send_bytes(mk(32'h100 + 32'(k), 4'd12 + 4'(k % 4), 3'd0, 20'h1, 16'h1, 32'h0), 0, 13);
        cycles(3);
        chk("t6_sat_drops", 128'(drop_s_cnt), 128'(5));
        chk("t6_sat_err", 128'(err_s), 128'(3));
        chk("t6_wide_err", 128'(err_cnt_r), 128'(5));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
